// File: rtl/mem_access_unit.sv
// Memory-stage access controller: turns the EX/MEM load/store into a
// req/ack transaction on the data-memory port and stalls the pipeline until it completes.
module mem_access_unit #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_mem_write,
    input  logic [ADDR_W-1:0] i_ex_addr,
    input  logic [DATA_W-1:0] i_ex_wdata,
    output logic              o_dm_req,
    output logic              o_dm_we,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [DATA_W-1:0] o_dm_wdata,
    input  logic [DATA_W-1:0] i_dm_rdata,
    input  logic              i_dm_ack,
    output logic [DATA_W-1:0] o_mem_out,
    output logic              o_mem_stall,
    output logic              o_mem_err,
    output logic [15:0]       o_stall_cnt
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t              r_state, w_next;
    logic                r_dm_req, r_dm_we, r_mem_err;
    logic [ADDR_W-1:0]   r_dm_addr;
    logic [DATA_W-1:0]   r_dm_wdata, r_mem_out;
    logic [7:0]          r_to_cnt;
    logic [15:0]         r_stall_cnt;
    logic                w_pending, w_start, w_timeout, w_finish, w_stall;

    assign w_pending = i_ex_valid & (i_ex_mem_read | i_ex_mem_write);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pending) w_next = S_REQ;
            S_REQ:   if (i_dm_ack || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stall is gated by reset so the pipeline is released the instant reset asserts.
    always_comb begin
        w_start   = 1'b0;
        w_timeout = 1'b0;
        w_finish  = 1'b0;
        w_stall   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = w_pending;
                w_stall = i_rst & w_pending;
            end
            S_REQ: begin
                w_timeout = ~i_dm_ack & (r_to_cnt == TO_LAST);
                w_finish  = i_dm_ack | w_timeout;
                w_stall   = i_rst;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_to_cnt   <= '0;
            r_mem_out  <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= w_timeout;
            if (w_start) begin
                r_dm_req   <= 1'b1;
                r_dm_we    <= i_ex_mem_write;
                r_dm_addr  <= i_ex_addr;
                r_dm_wdata <= i_ex_wdata;
                r_to_cnt   <= '0;
            end else if (r_state == S_REQ) begin
                if (w_finish) r_dm_req <= 1'b0;
                else          r_to_cnt <= r_to_cnt + 8'd1;
                // A store (including read+write) never touches the load result.
                if (!r_dm_we) begin
                    if (i_dm_ack)       r_mem_out <= i_dm_rdata;
                    else if (w_timeout) r_mem_out <= '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                              r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != '1)   r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign o_dm_req    = r_dm_req;
    assign o_dm_we     = r_dm_we;
    assign o_dm_addr   = r_dm_addr;
    assign o_dm_wdata  = r_dm_wdata;
    assign o_mem_out   = r_mem_out;
    assign o_mem_stall = w_stall;
    assign o_mem_err   = r_mem_err;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-timeline model checked every cycle,
// plus literal expectations from the directed scenarios.
module tb_mem_access_unit;
    localparam int TIMEOUT = 15;

    logic        clk = 0, rst = 0;
    logic        ex_valid = 0, ex_rd = 0, ex_wr = 0, dm_ack = 0;
    logic [11:0] ex_addr = 0;
    logic [15:0] ex_wdata = 0, dm_rdata = 0;
    logic        dm_req, dm_we, mem_stall, mem_err;
    logic [11:0] dm_addr;
    logic [15:0] dm_wdata, mem_out, stall_cnt;

    mem_access_unit #(.ADDR_W(12), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .i_ex_mem_read(ex_rd),
        .i_ex_mem_write(ex_wr), .i_ex_addr(ex_addr), .i_ex_wdata(ex_wdata),
        .o_dm_req(dm_req), .o_dm_we(dm_we), .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata),
        .i_dm_rdata(dm_rdata), .i_dm_ack(dm_ack), .o_mem_out(mem_out),
        .o_mem_stall(mem_stall), .o_mem_err(mem_err), .o_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int obs_stall = 0, obs_req = 0, obs_err = 0;
    logic chk_en = 0;

    // model state and per-cycle expectations
    logic [15:0] m_out = 0, m_cnt = 0;
    logic        exp_stall = 0, exp_req = 0, exp_err = 0, exp_we = 0;
    logic [11:0] exp_addr = 0;
    logic [15:0] exp_wdata = 0, exp_out = 0, exp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_stall", {31'd0, mem_stall}, {31'd0, exp_stall});
            chk("dm_req",    {31'd0, dm_req},    {31'd0, exp_req});
            chk("mem_err",   {31'd0, mem_err},   {31'd0, exp_err});
            chk("mem_out",   {16'd0, mem_out},   {16'd0, exp_out});
            chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, exp_cnt});
            if (exp_req) begin
                chk("dm_we",    {31'd0, dm_we},    {31'd0, exp_we});
                chk("dm_addr",  {20'd0, dm_addr},  {20'd0, exp_addr});
                chk("dm_wdata", {16'd0, dm_wdata}, {16'd0, exp_wdata});
            end
            obs_stall += int'(mem_stall);
            obs_req   += int'(dm_req);
            obs_err   += int'(mem_err);
        end
    end

    task automatic set_exp(input logic st, input logic rq, input logic er);
        exp_stall = st; exp_req = rq; exp_err = er;
        exp_out = m_out; exp_cnt = m_cnt;
        if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    endtask

    // One memory instruction: ack in REQ cycle ack_at (1-based), 0 = never (timeout).
    // Timeline: IDLE detect, k REQ cycles, DONE; k = ack_at or TIMEOUT.
    task automatic access(input logic rd, input logic wr, input logic [11:0] a,
                          input logic [15:0] wd, input int ack_at, input logic [15:0] rdat);
        int  k;
        bit  to;
        to = (ack_at == 0);
        k  = to ? TIMEOUT : ack_at;
        for (int c = 0; c <= k + 1; c++) begin
            @(posedge clk); #1;
            ex_valid = 1; ex_rd = rd; ex_wr = wr; ex_addr = a; ex_wdata = wd;
            dm_ack   = (c == ack_at) && (c >= 1);
            dm_rdata = dm_ack ? rdat : ~rdat;
            if (c == k + 1 && !wr) m_out = to ? 16'h0 : rdat;
            exp_we = wr; exp_addr = a; exp_wdata = wd;
            set_exp(c <= k, c >= 1 && c <= k, to && c == k + 1);
        end
        @(negedge clk); #1;
    endtask

    task automatic idle(input logic v, input logic rd, input logic ack, input logic [15:0] rdat);
        @(posedge clk); #1;
        ex_valid = v; ex_rd = rd; ex_wr = 0; dm_ack = ack; dm_rdata = rdat;
        set_exp(0, 0, 0);
        @(negedge clk); #1;
    endtask

    task automatic clr_obs();
        obs_stall = 0; obs_req = 0; obs_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
        chk("rst_dm_addr", {20'd0, dm_addr}, 32'd0);
        chk("rst_dm_wdata", {16'd0, dm_wdata}, 32'd0);
        chk("rst_mem_out", {16'd0, mem_out}, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        rst = 1;
        #1 chk_en = 1;
        idle(0, 0, 0, 0);

        // minimum load
        clr_obs();
        access(1, 0, 12'h010, 16'h0, 1, 16'hBEEF);
        chk("ld_stalls", obs_stall, 2);
        chk("ld_mem_out", {16'd0, mem_out}, 32'h0000BEEF);
        chk("ld_stall_cnt", {16'd0, stall_cnt}, 32'd2);

        idle(1, 0, 0, 0);          // ALU op
        idle(0, 0, 1, 16'h7777);   // stray ack in IDLE
        idle(0, 1, 0, 0);          // bubble marked as load

        // store with ack in 4th REQ cycle
        clr_obs();
        access(0, 1, 12'h3FF, 16'h1234, 4, 16'hAAAA);
        chk("st_req_cycles", obs_req, 4);
        chk("st_stalls", obs_stall, 5);
        chk("st_mem_out", {16'd0, mem_out}, 32'h0000BEEF);

        // read+write counts as store
        access(1, 1, 12'h155, 16'h0BAD, 1, 16'h5A5A);
        chk("rw_mem_out", {16'd0, mem_out}, 32'h0000BEEF);

        // timeout
        clr_obs();
        access(1, 0, 12'h0AB, 16'h0, 0, 16'h9999);
        chk("to_req_cycles", obs_req, TIMEOUT);
        chk("to_err_pulses", obs_err, 1);
        chk("to_stalls", obs_stall, TIMEOUT + 1);
        chk("to_mem_out", {16'd0, mem_out}, 32'd0);
        idle(0, 0, 0, 0);

        access(1, 0, 12'h011, 16'h0, 1, 16'h4321);
        chk("ld2_mem_out", {16'd0, mem_out}, 32'h00004321);

        // reset in the 2nd REQ cycle of a load
        @(posedge clk); #1;
        ex_valid = 1; ex_rd = 1; ex_wr = 0; ex_addr = 12'h020; dm_ack = 0;
        exp_we = 0; exp_addr = 12'h020; exp_wdata = ex_wdata;
        set_exp(1, 0, 0);
        @(posedge clk); #1;
        set_exp(1, 1, 0);
        @(posedge clk); #1;
        chk_en = 0;
        #2 rst = 0;
        #1;
        chk("mid_rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("mid_rst_mem_stall", {31'd0, mem_stall}, 32'd0);
        chk("mid_rst_mem_out", {16'd0, mem_out}, 32'd0);
        chk("mid_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("mid_rst_dm_addr", {20'd0, dm_addr}, 32'd0);
        chk("mid_rst_mem_err", {31'd0, mem_err}, 32'd0);
        ex_valid = 0; ex_rd = 0;
        m_out = 0; m_cnt = 0;
        @(negedge clk);
        rst = 1;
        #1 chk_en = 1;
        idle(0, 0, 1, 16'h5555);   // late ack after release
        chk("late_ack_mem_out", {16'd0, mem_out}, 32'd0);

        // back-to-back load, store, ALU
        clr_obs();
        access(1, 0, 12'h030, 16'h0, 1, 16'hA5A5);
        access(0, 1, 12'h031, 16'h0F0F, 1, 16'h0);
        idle(1, 0, 0, 0);
        chk("b2b_stalls", obs_stall, 4);
        chk("b2b_stall_cnt", {16'd0, stall_cnt}, 32'd4);
        chk("b2b_mem_out", {16'd0, mem_out}, 32'h0000A5A5);

        // saturation
        #1 force dut.r_stall_cnt = 16'hFFFE;
        #1 release dut.r_stall_cnt;
        m_cnt = 16'hFFFE;
        access(1, 0, 12'h040, 16'h0, 2, 16'h1357);
        chk("sat_stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
        idle(0, 0, 0, 0);
        chk("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller between the EX/MEM and MEM/WB pipeline registers. It turns the load/store request held in EX/MEM into a request/acknowledge transaction on the data-memory port and stalls the upstream pipeline until the access completes. It presents the load result to MEM/WB for capture into its memory-output field. It also flags accesses that never complete and counts stall cycles for performance monitoring.

## Interface
- ADDR_W, 12: data-memory address width; the low ADDR_W bits of the ALU result are used.
- DATA_W, 16: data word width; matches the pipeline word length.
- TIMEOUT, 15: maximum REQ cycles without dm_ack before the access is aborted; legal range 1..255.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- ex_valid  in  1  EX/MEM holds a real instruction, not a bubble.
- ex_mem_read  in  1  the instruction is a load.
- ex_mem_write  in  1  the instruction is a store.
- ex_addr  in  ADDR_W  effective address (EX/MEM ALU result).
- ex_wdata  in  DATA_W  store data (EX/MEM register-file out2).
- dm_req  out  1  memory request; held until acknowledged.
- dm_we  out  1  1 = write, 0 = read; valid while dm_req = 1.
- dm_addr  out  ADDR_W  request address; stable while dm_req = 1.
- dm_wdata  out  DATA_W  write data; stable while dm_req = 1.
- dm_rdata  in  DATA_W  read data; sampled only in a cycle with dm_req = 1 and dm_ack = 1.
- dm_ack  in  1  one-cycle completion from memory.
- mem_out  out  DATA_W  last load result, feeding the MEM/WB memory-output input.
- mem_stall  out  1  combinational; IF/ID, ID/EX and EX/MEM must hold while this is 1.
- mem_err  out  1  one-cycle pulse on timeout abort.
- stall_cnt  out  16  saturating count of cycles with mem_stall = 1.

## Operation
- FSM states: IDLE, REQ, DONE.
- An access is pending when ex_valid = 1 and (ex_mem_read = 1 or ex_mem_write = 1).
- IDLE with an access pending:
  - Latch ex_addr, ex_wdata and dm_we (= ex_mem_write) into request registers.
  - Go to REQ.
  - Assert mem_stall.
- IDLE with no access pending:
  - Stay in IDLE with mem_stall = 0.
  - mem_out holds its previous value.
- If ex_mem_read and ex_mem_write are both 1, the access is a write and mem_out is not updated.
- REQ:
  - dm_req = 1 and mem_stall = 1.
  - On dm_ack = 1: if the access is a read, mem_out <= dm_rdata. Go to DONE.
  - Without dm_ack: the timeout counter increments.
  - When the counter reaches TIMEOUT with no ack: go to DONE, drive mem_out to 0 for a read, pulse mem_err in the DONE cycle.
- DONE:
  - dm_req = 0 and mem_stall = 0, so MEM/WB captures mem_out and EX/MEM advances at the end of this cycle.
  - The next state is always IDLE; back-to-back accesses do not overlap.
- dm_req, dm_we, dm_addr and dm_wdata are registered outputs.
  - dm_addr and dm_wdata come from the request registers and never change while dm_req = 1.
- The timeout counter clears on entry to REQ.
- stall_cnt increments every cycle mem_stall = 1 and saturates at 16'hFFFF.

## Timing
- Reset values: state IDLE, dm_req 0, dm_we 0, dm_addr 0, dm_wdata 0, mem_out 0, mem_err 0, stall_cnt 0, mem_stall 0.
- Reset asserted mid-access:
  - dm_req drops asynchronously.
  - The transaction is abandoned.
  - A late dm_ack arriving after reset release is ignored in IDLE.
- Minimum access, ack in the first REQ cycle:
  - Cycle 0 is IDLE detect, cycle 1 is REQ, cycle 2 is DONE.
  - mem_stall is high for 2 cycles; the instruction occupies EX/MEM for 3 cycles.
- Each REQ cycle without ack adds one stall cycle.
- Timeout gives TIMEOUT + 1 stall cycles, with mem_err high in the following DONE cycle.
- Non-memory instructions add zero latency.
- dm_ack outside REQ is ignored, with no state change and no mem_out update.
- ex_valid = 0 with ex_mem_read = 1 starts no access.

## Test plan
- Load, addr 0x010, dm_ack in the first REQ cycle, dm_rdata = 0xBEEF:
  - mem_stall high for exactly 2 cycles.
  - mem_out = 0xBEEF during DONE.
  - stall_cnt = 2.
- Store, addr 0x3FF, data 0x1234, ack after 4 REQ cycles:
  - dm_req high for 4 cycles with dm_we = 1, dm_addr = 0x3FF, dm_wdata = 0x1234 constant throughout.
  - mem_out unchanged.
  - mem_stall high for 5 cycles.
- Load with dm_ack held low and TIMEOUT = 15:
  - dm_req high for 15 cycles, then drops.
  - mem_err is a single-cycle pulse in DONE.
  - mem_out = 0.
  - FSM returns to IDLE.
- Reset pulled low in the 2nd REQ cycle of a load, then ack pulsed after release:
  - All outputs return to reset values immediately.
  - The ack causes no mem_out change.
- Back-to-back load, store, then an ALU op, all acked immediately:
  - Accesses are serialized, each with 2 stall cycles.
  - The ALU op gets 0 stall cycles.
  - stall_cnt = 4.
- Force stall_cnt to 16'hFFFE and run a 3-stall access:
  - stall_cnt ends at 16'hFFFF with no wrap to 0.
